// File: rtl/z_seq_pkg.sv
// Shared encodings for the Z-register sequencer and the Z register itself.
package z_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_EXEC, S_ZOUT, S_ZLAT, S_WB, S_MOVWB
  } state_t;

  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_ITER = 2'b01;
  localparam logic [1:0] OP_MOVE = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  localparam logic [1:0] ZCTL_HOLD  = 2'b00;
  localparam logic [1:0] ZCTL_OUT   = 2'b01;
  localparam logic [1:0] ZCTL_LATCH = 2'b10;

  function automatic logic [1:0] zctl_of(state_t s);
    case (s)
      S_EXEC, S_ZLAT: zctl_of = ZCTL_LATCH;
      S_ZOUT, S_WB:   zctl_of = ZCTL_OUT;
      default:        zctl_of = ZCTL_HOLD;
    endcase
  endfunction
endpackage

// File: rtl/z_sequencer_if.sv
// Request/control bundle between the issuing stage and the Z sequencer.
// Z_SEQ_ABORT_EN adds the abort request line.
interface z_sequencer_if #(parameter int SHAMT_W = 5) ();
  logic               start;
  logic [1:0]         op_class;
  logic [SHAMT_W-1:0] shamt;
  logic               ab_latch;
  logic [1:0]         z_ctrl;
  logic               alu_src_z;
  logic               rf_we;
  logic               busy;
  logic               done;
  logic               err;
`ifdef Z_SEQ_ABORT_EN
  logic               abort;

  modport master (output start, op_class, shamt, abort,
                  input ab_latch, z_ctrl, alu_src_z, rf_we, busy, done, err);
  modport slave  (input start, op_class, shamt, abort,
                  output ab_latch, z_ctrl, alu_src_z, rf_we, busy, done, err);
`else
  modport master (output start, op_class, shamt,
                  input ab_latch, z_ctrl, alu_src_z, rf_we, busy, done, err);
  modport slave  (input start, op_class, shamt,
                  output ab_latch, z_ctrl, alu_src_z, rf_we, busy, done, err);
`endif
endinterface

// File: rtl/z_seq_iter_cnt.sv
// ITER pass counter: load with shamt, decrement once per ZLAT, saturate at zero.
module z_seq_iter_cnt #(parameter int W = 5) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] din,
  output logic         zero,
  output logic         last
);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)                   cnt <= '0;
    else if (load)              cnt <= din;
    else if (dec && cnt != '0)  cnt <= cnt - ONE;
  end

  assign zero = (cnt == '0);
  assign last = (cnt == ONE);
endmodule

// File: rtl/z_sequencer.sv
// Micro-sequencer driving operand latches, Z register and RF write for ALU/ITER/MOVE ops.
// Z_SEQ_ABORT_EN enables the abort input that drops any in-flight operation.
module z_sequencer
  import z_seq_pkg::*;
#(
  parameter int SHAMT_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  z_sequencer_if.slave  bus
);
  state_t     state, nxt;
  logic [1:0] op;
  logic       load, dec, cnt_zero, cnt_last, abort_hit;

  assign load = (state == S_IDLE) && bus.start;
  assign dec  = (state == S_ZLAT);

`ifdef Z_SEQ_ABORT_EN
  assign abort_hit = bus.abort && (state != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  z_seq_iter_cnt #(.W(SHAMT_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .dec  (dec),
    .din  (bus.shamt),
    .zero (cnt_zero),
    .last (cnt_last)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (bus.start) nxt = S_READ;
      S_READ:  case (op)
                 OP_ALU, OP_ITER: nxt = S_EXEC;
                 OP_MOVE:         nxt = S_MOVWB;
                 default:         nxt = S_IDLE;
               endcase
      S_EXEC:  nxt = (op == OP_ALU || cnt_zero) ? S_WB : S_ZOUT;
      S_ZOUT:  nxt = S_ZLAT;
      // Counter still holds the pre-decrement value here, so 1 means this is the last pass.
      S_ZLAT:  nxt = cnt_last ? S_WB : S_ZOUT;
      S_WB, S_MOVWB: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (abort_hit) nxt = S_IDLE;
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      op            <= OP_ALU;
      bus.ab_latch  <= 1'b0;
      bus.z_ctrl    <= ZCTL_HOLD;
      bus.alu_src_z <= 1'b0;
      bus.rf_we     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      state         <= nxt;
      if (load) op  <= bus.op_class;
      bus.ab_latch  <= (nxt == S_READ);
      bus.z_ctrl    <= zctl_of(nxt);
      bus.alu_src_z <= (nxt == S_ZOUT) || (nxt == S_ZLAT);
      bus.rf_we     <= (nxt == S_WB) || (nxt == S_MOVWB);
      bus.busy      <= (nxt != S_IDLE);
      bus.done      <= (nxt == S_WB) || (nxt == S_MOVWB);
      bus.err       <= load && (bus.op_class == OP_RSV);
    end
  end
endmodule

// File: tb/tb_z_sequencer.sv
// Scoreboard bench: stimulus pushes per-cycle expected output vectors, monitor pops and compares.
// Define Z_SEQ_ABORT_EN to also exercise the abort path.
module tb_z_sequencer;
  localparam int SW = 5;

  // {ab_latch, z_ctrl[1:0], alu_src_z, rf_we, busy, done, err}
  localparam logic [7:0] V_IDLE = 8'b0_00_0_0_0_0_0;
  localparam logic [7:0] V_READ = 8'b1_00_0_0_1_0_0;
  localparam logic [7:0] V_ERR  = 8'b1_00_0_0_1_0_1;
  localparam logic [7:0] V_EXEC = 8'b0_10_0_0_1_0_0;
  localparam logic [7:0] V_ZOUT = 8'b0_01_1_0_1_0_0;
  localparam logic [7:0] V_ZLAT = 8'b0_10_1_0_1_0_0;
  localparam logic [7:0] V_WB   = 8'b0_01_0_1_1_1_0;
  localparam logic [7:0] V_MOV  = 8'b0_00_0_1_1_1_0;

  typedef struct {
    string      name;
    logic [7:0] v;
  } exp_t;

  logic clk, rst;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] outv;

  z_sequencer_if #(.SHAMT_W(SW)) zs ();

  z_sequencer #(.SHAMT_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (zs.slave)
  );

  assign outv = {zs.ab_latch, zs.z_ctrl, zs.alu_src_z, zs.rf_we, zs.busy, zs.done, zs.err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (outv !== e.v) begin
          errors++;
          $display("FAIL %s: got %b expected %b", e.name, outv, e.v);
        end
      end
    end
  end

  task automatic push(input string n, input logic [7:0] v);
    exp_t e;
    e.name = n;
    e.v    = v;
    exp_q.push_back(e);
  endtask

  // Per-cycle expectation of one operation, starting with the READ cycle and ending with IDLE.
  task automatic trace(input logic [1:0] oc, input int sh, input string tag, output int n);
    n = 0;
    if (oc == 2'b11) begin
      push({tag, "/read_err"}, V_ERR);
      push({tag, "/idle"}, V_IDLE);
      n = 2;
      return;
    end
    push({tag, "/read"}, V_READ); n++;
    if (oc == 2'b10) begin
      push({tag, "/movwb"}, V_MOV); n++;
    end else begin
      push({tag, "/exec"}, V_EXEC); n++;
      if (oc == 2'b01)
        for (int i = 0; i < sh; i++) begin
          push($sformatf("%s/zout%0d", tag, i), V_ZOUT);
          push($sformatf("%s/zlat%0d", tag, i), V_ZLAT);
          n += 2;
        end
      push({tag, "/wb"}, V_WB); n++;
    end
    push({tag, "/idle"}, V_IDLE); n++;
  endtask

  // Called at a negedge; returns at the negedge of the trailing IDLE cycle.
  task automatic run(input logic [1:0] oc, input int sh, input string tag);
    int n;
    zs.start    = 1'b1;
    zs.op_class = oc;
    zs.shamt    = SW'(sh);
    trace(oc, sh, tag, n);
    @(negedge clk);
    zs.start = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    zs.start = 1'b0;
    zs.op_class = 2'b00;
    zs.shamt = '0;
`ifdef Z_SEQ_ABORT_EN
    zs.abort = 1'b0;
`endif
    @(negedge clk);
    push("reset0", V_IDLE);
    push("reset1", V_IDLE);
    zs.start = 1'b1;
    repeat (2) @(negedge clk);
    zs.start = 1'b0;
    rst = 1'b1;
    push("post_reset", V_IDLE);
    @(negedge clk);

    run(2'b00, 0,  "alu");
    run(2'b01, 3,  "iter3");
    run(2'b01, 0,  "iter0");
    run(2'b10, 0,  "move");
    run(2'b11, 0,  "rsv");
    run(2'b01, 31, "iter31");
    run(2'b10, 7,  "move_b2b");

    // start held through an ITER op; the op_class change mid-op must be ignored
    zs.start = 1'b1;
    zs.op_class = 2'b01;
    zs.shamt = SW'(5);
    trace(2'b01, 5, "held_iter5", n);
    @(negedge clk);
    zs.op_class = 2'b00;
    zs.shamt = '0;
    repeat (n - 1) @(negedge clk);
    trace(2'b00, 0, "held_alu", n);
    @(negedge clk);
    zs.start = 1'b0;
    repeat (n - 1) @(negedge clk);

    // reset asserted during the first ZLAT
    zs.start = 1'b1;
    zs.op_class = 2'b01;
    zs.shamt = SW'(3);
    push("rstmid/read", V_READ);
    push("rstmid/exec", V_EXEC);
    push("rstmid/zout", V_ZOUT);
    push("rstmid/zlat", V_ZLAT);
    push("rstmid/after_rst", V_IDLE);
    push("rstmid/idle", V_IDLE);
    @(negedge clk);
    zs.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

`ifdef Z_SEQ_ABORT_EN
    zs.start = 1'b1;
    zs.op_class = 2'b01;
    zs.shamt = SW'(3);
    push("abort/read", V_READ);
    push("abort/exec", V_EXEC);
    push("abort/zout", V_ZOUT);
    push("abort/after", V_IDLE);
    push("abort/idle", V_IDLE);
    @(negedge clk);
    zs.start = 1'b0;
    repeat (2) @(negedge clk);
    zs.abort = 1'b1;
    @(negedge clk);
    zs.abort = 1'b0;
    @(negedge clk);
`endif

    run(2'b01, 2, "final_iter2");

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/z_sequencer.md
Z_SEQUENCER -- requirements
Module: z_sequencer

Interface
REQ-001 SHALL have parameter SHAMT_W, default 5, meaning width of the iteration count (maximum 2^SHAMT_W-1 passes).
REQ-002 SHALL have the clock input clk, 1 bit; the single clock, with all state updating on its rising edge.
REQ-003 SHALL have the reset input rst, 1 bit; one clock; reset is synchronous and active-low.
REQ-004 SHALL have input start, 1 bit; an operation request, sampled only in IDLE.
REQ-005 SHALL have input op_class, 2 bits; 00 ALU, 01 ITER (repeated pass through Z), 10 MOVE (no Z use), 11 reserved.
REQ-006 SHALL have input shamt, SHAMT_W bits; the ITER pass count, captured with start.
REQ-007 SHALL have output ab_latch, 1 bit; latches the A and B operand registers.
REQ-008 SHALL have output z_ctrl, 2 bits; drives the Z register: 00 hold, 01 drive output, 10 latch input; 11 is never issued.
REQ-009 SHALL have output alu_src_z, 1 bit; selects Z output as the ALU A-input (feedback path).
REQ-010 SHALL have output rf_we, 1 bit; register-file write enable.
REQ-011 SHALL have output busy, 1 bit; high in every state except IDLE.
REQ-012 SHALL have output done, 1 bit; a one-cycle completion pulse.
REQ-013 SHALL have output err, 1 bit; a one-cycle pulse on reserved op_class.

Function
REQ-014 SHALL implement the states IDLE, READ, EXEC, ZOUT, ZLAT, WB and MOVWB.
REQ-015 SHALL, in IDLE with start=1, capture op_class and shamt, then go to READ the next cycle; start while busy SHALL be ignored.
REQ-016 SHALL, in READ, assert ab_latch=1; the next state SHALL be EXEC for ALU/ITER, MOVWB for MOVE, and IDLE for reserved.
REQ-017 SHALL pulse err=1 in the READ cycle when op_class=11; done SHALL NOT be asserted for that operation.
REQ-018 SHALL, in EXEC, assert z_ctrl=10 with alu_src_z=0; the next state SHALL be WB for ALU, or for ITER with count=0, otherwise ZOUT.
REQ-019 SHALL, in ZOUT, assert z_ctrl=01 and alu_src_z=1, and go to ZLAT.
REQ-020 SHALL, in ZLAT, assert z_ctrl=10 and alu_src_z=1 and decrement count; it SHALL go to WB when the count reaches 0, otherwise to ZOUT.
REQ-021 SHALL, in WB, assert z_ctrl=01, rf_we=1 and done=1, and go to IDLE.
REQ-022 SHALL, in MOVWB, assert rf_we=1 and done=1 with z_ctrl=00, and go to IDLE.
REQ-023 SHALL meet these latencies, measured from the start-sampled edge to done: ALU 3 cycles; ITER 3+2*shamt cycles; MOVE 2 cycles.
REQ-024 SHALL drive every output not listed for the current state to 0; z_ctrl SHALL never be 11.
REQ-025 SHALL accept a new start in the IDLE cycle immediately following done, giving back-to-back operation with no bubble beyond IDLE.
REQ-026 SHALL, for shamt = 2^SHAMT_W-1, perform exactly that many ZOUT/ZLAT pairs with no count wrap.

Reset
REQ-027 SHALL, when rst=0 at a clock edge, enter IDLE and clear the count and captured op.
REQ-028 SHALL hold ab_latch=0, z_ctrl=00, alu_src_z=0, rf_we=0, busy=0, done=0 and err=0 during and after reset.
REQ-029 SHALL, on reset mid-operation, abandon the operation with no rf_we and no done.

Configuration
REQ-030 SHALL, with Z_SEQ_ABORT_EN defined, add input abort (1 bit): abort=1 in any non-IDLE state forces IDLE next cycle, with no rf_we and no done that cycle and outputs as in REQ-024.
REQ-031 SHALL, without Z_SEQ_ABORT_EN, have no abort port, and every accepted operation SHALL run to completion.

Structure
REQ-032 SHALL take its state encoding, the op_class codes (OP_ALU, OP_ITER, OP_MOVE) and the z_ctrl codes (ZCTL_HOLD=00, ZCTL_OUT=01, ZCTL_LATCH=10) from shared package z_seq_pkg, which the Z register user also imports.
REQ-033 SHALL implement the pass counter (load, decrement, zero flag) as sub-module z_seq_iter_cnt.

Verification
REQ-034 SHALL verify: ALU start at cycle 0 -> ab_latch at 1, z_ctrl=10 at 2, z_ctrl=01 with rf_we and done at 3, busy low at 4.
REQ-035 SHALL verify: ITER with shamt=3 -> EXEC, then exactly 3 ZOUT/ZLAT pairs, with done at cycle 9.
REQ-036 SHALL verify: ITER with shamt=0 -> identical timing to ALU, with alu_src_z never asserted.
REQ-037 SHALL verify: MOVE -> done at cycle 2, z_ctrl=00 throughout; op_class=11 -> err at cycle 1, no done, busy low at cycle 2.
REQ-038 SHALL verify: start held high during an ITER shamt=5 operation -> the second op begins only after done; rst=0 during ZLAT -> all outputs 0 next cycle, with no done.
REQ-039 SHALL verify, with Z_SEQ_ABORT_EN: abort during ZOUT -> IDLE next cycle, with rf_we never asserted.
